sr_ff_bank: RTL and testbench
=============================

// Module: sr_ff_bank
// PURPOSE
//  Bank of WIDTH clocked SR flip-flops: clocked, glitch-free counterpart of the gate-level SR latches.
//  Consumes per-bit set/reset requests; each bit has its own 3-state FSM that traps the forbidden
//  S=R=1 condition instead of oscillating. Saturating error counter feeds status logic downstream.
// PARAMETERS
//  WIDTH    4  number of independent SR bits
//  CNT_W    4  width of forbidden-event counter (saturates at 2**CNT_W-1)
//  ERR_HOLD 1  1: ERR is sticky until err_clr; 0: ERR exits on next legal S/R
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        asynchronous, active-high reset
//  s        in   WIDTH    set request per bit, sampled on clk
//  r        in   WIDTH    reset request per bit, sampled on clk
//  err_clr  in   1        sync clear of all ERR bits and err_cnt
//  ps_n     in   WIDTH    active-low preset (SR_PRESET_EN only)
//  pr_n     in   WIDTH    active-low clear (SR_PRESET_EN only)
//  q        out  WIDTH    flip-flop outputs
//  qb       out  WIDTH    complement; ERR bits drive q=0 and qb=0
//  err      out  WIDTH    bit is in ERR state
//  err_cnt  out  CNT_W    saturating count of forbidden-input cycles, all bits summed
// BEHAVIOUR
//  Reset: all bits to LO; q=0, qb=all ones, err=0, err_cnt=0. Async assert, sync-to-clk deassert by user.
//  Per-bit FSM {LO, HI, ERR}, one transition per clk edge, latency 1 cycle (q valid after edge):
//   LO : s&~r -> HI; s&r -> ERR; else hold
//   HI : ~s&r -> LO; s&r -> ERR; else hold
//   ERR: err_clr -> LO (priority over s/r)
//        ERR_HOLD=0: ~s&r -> LO, s&~r -> HI, else stay; ERR_HOLD=1: stay until err_clr
//  Outputs: LO -> q=0,qb=1; HI -> q=1,qb=0; ERR -> q=0,qb=0,err=1 (never q=qb=1).
//  err_cnt: += popcount(s&r) each cycle, including bits already in ERR; saturates, never wraps.
//   err_clr same cycle as new forbidden input: clear wins, cnt=0, bits to LO.
//  Mid-operation rst: immediate return to reset values regardless of FSM state.
//  Popcount adder is CNT_W+$clog2(WIDTH)+1 bits wide, clamped to max before register.
// CONFIGURATION
//  SR_PRESET_EN defined: ps_n/pr_n present, sampled on clk, priority above s/r/err_clr.
//   ps_n=0,pr_n=1 -> HI; pr_n=0,ps_n=1 -> LO; both 0 -> ERR and err_cnt +1 for that bit.
//  SR_PRESET_EN undefined: ps_n/pr_n ports absent; FSM driven by s/r/err_clr only.
// TESTING
//  T1 rst=1 mid-run with bit0 HI -> same cycle q=0, qb=4'hF, err=0, err_cnt=0.
//  T2 s=4'b0001 one cycle, then s=r=0 -> q=4'b0001 after edge and held; r=4'b0001 -> q=0.
//  T3 s=r=4'b0011 one cycle -> err=4'b0011, q[1:0]=0, qb[1:0]=0, err_cnt=2.
//  T4 ERR_HOLD=1, bit0 ERR, s=4'b0001 -> stays ERR; err_clr=1 -> LO, err_cnt=0.
//  T5 s=r=4'hF for 8 cycles with CNT_W=4 -> err_cnt saturates at 15, no wrap.
//  T6 (SR_PRESET_EN) ps_n=4'b1110 with r=4'b0001 -> q[0]=1; ps_n=pr_n=4'b1110 -> bit0 ERR.

Source files
------------

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with a trapping ERR state and a saturating forbidden-input counter.
// Optional feature macro: SR_PRESET_EN adds active-low ps_n/pr_n inputs, sampled on clk and taking priority over s/r/err_clr.
module sr_ff_bank #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 4,
    parameter int ERR_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
`ifdef SR_PRESET_EN
    input  logic [WIDTH-1:0] ps_n,
    input  logic [WIDTH-1:0] pr_n,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SUM_W = CNT_W + $clog2(WIDTH) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {LO = 2'd0, HI = 2'd1, ERR = 2'd2} sr_state_t;

    sr_state_t        state_p1  [WIDTH];
    sr_state_t        state_nxt [WIDTH];
    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] fbd;

    function automatic logic [SUM_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + SUM_W'(v[i]);
        end
        return acc;
    endfunction

    // Widen, add, then clamp so the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + inc;
        return (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        fbd = s & r;
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state_p1[i];
            if (err_clr && (state_p1[i] == ERR || fbd[i])) begin
                state_nxt[i] = LO;
            end else begin
                case (state_p1[i])
                    LO:  if (fbd[i]) state_nxt[i] = ERR;
                         else if (s[i]) state_nxt[i] = HI;
                    HI:  if (fbd[i]) state_nxt[i] = ERR;
                         else if (r[i]) state_nxt[i] = LO;
                    ERR: if (ERR_HOLD == 0) begin
                             if (r[i] && !s[i]) state_nxt[i] = LO;
                             else if (s[i] && !r[i]) state_nxt[i] = HI;
                         end
                    default: state_nxt[i] = LO;
                endcase
            end
`ifdef SR_PRESET_EN
            if (!ps_n[i] && !pr_n[i]) state_nxt[i] = ERR;
            else if (!ps_n[i])        state_nxt[i] = HI;
            else if (!pr_n[i])        state_nxt[i] = LO;
`endif
        end
`ifdef SR_PRESET_EN
        // Preset-forced ERR bits still count; bits under preset ignore s/r.
        if (err_clr) cnt_nxt = sat_add('0, popcount(~ps_n & ~pr_n));
        else         cnt_nxt = sat_add(cnt_p1, popcount((~ps_n & ~pr_n) | (fbd & ps_n & pr_n)));
`else
        if (err_clr) cnt_nxt = '0;
        else         cnt_nxt = sat_add(cnt_p1, popcount(fbd));
`endif
    end

    // ---- stage p1: per-bit FSM state and error counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) state_p1[i] <= LO;
            cnt_p1 <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) state_p1[i] <= state_nxt[i];
            cnt_p1 <= cnt_nxt;
        end
    end

    always_comb begin
        q   = '0;
        qb  = '0;
        err = '0;
        for (int i = 0; i < WIDTH; i++) begin
            q[i]   = (state_p1[i] == HI);
            qb[i]  = (state_p1[i] == LO);
            err[i] = (state_p1[i] == ERR);
        end
    end

    assign err_cnt = cnt_p1;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: stimulus pushes expected outputs from a rule-level model, a monitor pops and compares.
module tb_sr_ff_bank;

    localparam int WIDTH    = 4;
    localparam int CNT_W    = 4;
    localparam int ERR_HOLD = 1;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] s, r;
    logic             err_clr;
`ifdef SR_PRESET_EN
    logic [WIDTH-1:0] ps_n, pr_n;
`endif
    logic [WIDTH-1:0] q, qb, err;
    logic [CNT_W-1:0] err_cnt;

    sr_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_HOLD(ERR_HOLD)) dut (
        .clk(clk), .rst(rst), .s(s), .r(r), .err_clr(err_clr),
`ifdef SR_PRESET_EN
        .ps_n(ps_n), .pr_n(pr_n),
`endif
        .q(q), .qb(qb), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q, qb, err;
        int               cnt;
        string            tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: each bit is "off", "on" or "fault"; counter is a plain clamped integer.
    int   bit_mode[WIDTH];
    int   m_cnt;
    logic sim_done = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.q = '0; e.qb = '0; e.err = '0;
        for (int i = 0; i < WIDTH; i++) begin
            e.q[i]   = (bit_mode[i] == 1);
            e.qb[i]  = (bit_mode[i] == 0);
            e.err[i] = (bit_mode[i] == 2);
        end
        e.cnt = m_cnt;
        e.tag = tag;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) bit_mode[i] = 0;
        m_cnt = 0;
    endtask

    task automatic step(input logic [WIDTH-1:0] si, input logic [WIDTH-1:0] ri,
                        input logic clr, input string tag);
        int n;
        @(negedge clk);
        s = si; r = ri; err_clr = clr;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (si[i] && ri[i]) n++;
            if (clr && (bit_mode[i] == 2 || (si[i] && ri[i]))) bit_mode[i] = 0;
            else if (si[i] && ri[i] && bit_mode[i] != 2) bit_mode[i] = 2;
            else if (bit_mode[i] == 2) begin
                if (ERR_HOLD == 0 && si[i] != ri[i]) bit_mode[i] = si[i] ? 1 : 0;
            end else if (si[i] && !ri[i]) bit_mode[i] = 1;
            else if (ri[i] && !si[i]) bit_mode[i] = 0;
        end
        m_cnt = clr ? 0 : ((m_cnt + n > CMAX) ? CMAX : m_cnt + n);
        exp_q.push_back(model_out(tag));
    endtask

    // Monitor: outputs are valid every cycle, just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".q"},   int'(q),       int'(e.q));
                chk({e.tag, ".qb"},  int'(qb),      int'(e.qb));
                chk({e.tag, ".err"}, int'(err),     int'(e.err));
                chk({e.tag, ".cnt"}, int'(err_cnt), e.cnt);
                if ((q & qb) != '0) chk({e.tag, ".q_and_qb"}, int'(q & qb), 0);
            end
        end
    end

    initial begin
        #200000;
        if (!sim_done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

    initial begin
        rst = 1'b1; s = '0; r = '0; err_clr = 1'b0;
`ifdef SR_PRESET_EN
        ps_n = '1; pr_n = '1;
`endif
        model_reset();
        #12;
        chk("reset.q", int'(q), 0);
        chk("reset.qb", int'(qb), 'hF);
        chk("reset.err", int'(err), 0);
        chk("reset.cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // set, hold, reset
        step(4'b0001, 4'b0000, 1'b0, "t2_set");
        step(4'b0000, 4'b0000, 1'b0, "t2_hold");
        step(4'b0000, 4'b0001, 1'b0, "t2_rst");
        // forbidden pair traps into ERR
        step(4'b0011, 4'b0011, 1'b0, "t3_fbd");
        step(4'b0001, 4'b0000, 1'b0, "t4_sticky");
        step(4'b0000, 4'b0000, 1'b1, "t4_clr");
        // saturation
        for (int k = 0; k < 8; k++) step(4'hF, 4'hF, 1'b0, "t5_sat");
        // clear in the same cycle as a new forbidden input
        step(4'b0110, 4'b0110, 1'b1, "clr_vs_fbd");

        // mid-run async reset with bit0 HI
        step(4'b0101, 4'b0000, 1'b0, "t1_pre");
        @(negedge clk);
        s = '0; r = '0; err_clr = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t1.q", int'(q), 0);
        chk("t1.qb", int'(qb), 'hF);
        chk("t1.err", int'(err), 0);
        chk("t1.cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0), "rand");
        end
        @(negedge clk);
        s = '0; r = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        sim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
